// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - requester, clear-control and RAM-side signal bundle for ram_arbiter
interface ram_arbiter_if #(
  parameter int word_size = 8,
  parameter int addr_size = 10
);
  logic                 clr_start;
  logic                 clr_busy;

  logic                 a_req;
  logic                 a_wr;
  logic [addr_size-1:0] a_addr;
  logic [word_size-1:0] a_wdata;
  logic                 a_ack;
  logic [word_size-1:0] a_rdata;

  logic                 b_req;
  logic                 b_wr;
  logic [addr_size-1:0] b_addr;
  logic [word_size-1:0] b_wdata;
  logic                 b_ack;
  logic [word_size-1:0] b_rdata;

  logic [addr_size-1:0] ram_addr;
  logic [word_size-1:0] ram_din;
  logic                 ram_wr;
  logic                 ram_cs;
  logic [word_size-1:0] ram_dout;

  // arbiter side
  modport slave (
    input  clr_start,
    input  a_req, a_wr, a_addr, a_wdata,
    input  b_req, b_wr, b_addr, b_wdata,
    input  ram_dout,
    output clr_busy,
    output a_ack, a_rdata,
    output b_ack, b_rdata,
    output ram_addr, ram_din, ram_wr, ram_cs
  );

  // requester / RAM side
  modport master (
    output clr_start,
    output a_req, a_wr, a_addr, a_wdata,
    output b_req, b_wr, b_addr, b_wdata,
    output ram_dout,
    input  clr_busy,
    input  a_ack, a_rdata,
    input  b_ack, b_rdata,
    input  ram_addr, ram_din, ram_wr, ram_cs
  );
endinterface

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin two-requester single-port RAM arbiter with memory clear sequencer
module ram_arbiter #(
  parameter int word_size   = 8,
  parameter int addr_size   = 10,
  parameter int memory_size = 1024
) (
  input  logic          clk,
  input  logic          rst,
  ram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACK   = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  localparam logic [addr_size-1:0] last_addr = addr_size'(memory_size - 1);

  state_t               state_q, state_d;
  logic                 ptr_q, ptr_d;         // 1: B wins the next tie
  logic [addr_size-1:0] cnt_q, cnt_d;
  logic                 a_ack_q, a_ack_d;
  logic                 b_ack_q, b_ack_d;
  logic [word_size-1:0] a_rdata_q, a_rdata_d;
  logic [word_size-1:0] b_rdata_q, b_rdata_d;

  logic                 grant_a, grant_b;
  logic                 win_wr;
  logic [addr_size-1:0] win_addr;
  logic [word_size-1:0] win_wdata;

  logic                 ram_cs_c, ram_wr_c;
  logic [addr_size-1:0] ram_addr_c;
  logic [word_size-1:0] ram_din_c;
  logic                 clr_busy_c;

  // Winner selection: only in IDLE and only when no clear is being started
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state_q == S_IDLE && !bus.clr_start) begin
      if (bus.a_req && (!bus.b_req || !ptr_q)) begin
        grant_a = 1'b1;
      end else if (bus.b_req) begin
        grant_b = 1'b1;
      end
    end
    win_wr    = grant_b ? bus.b_wr    : bus.a_wr;
    win_addr  = grant_b ? bus.b_addr  : bus.a_addr;
    win_wdata = grant_b ? bus.b_wdata : bus.a_wdata;
  end

  // Next-state logic: clear start beats requests, ACK lasts one cycle, clear sweeps every word once
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.clr_start) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end else if (grant_a || grant_b) begin
          state_d = S_ACK;
          ptr_d   = grant_a;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      S_CLEAR: begin
        if (cnt_q == last_addr) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Ack pulses and per-requester read data capture
  always_comb begin
    a_ack_d   = grant_a;
    b_ack_d   = grant_b;
    a_rdata_d = (grant_a && !bus.a_wr) ? bus.ram_dout : a_rdata_q;
    b_rdata_d = (grant_b && !bus.b_wr) ? bus.ram_dout : b_rdata_q;
  end

  // RAM strobes; held quiet while reset is asserted so an interrupted clear commits nothing more
  always_comb begin
    ram_cs_c   = 1'b0;
    ram_wr_c   = 1'b0;
    ram_addr_c = '0;
    ram_din_c  = '0;
    clr_busy_c = (state_q == S_CLEAR);
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          if (grant_a || grant_b) begin
            ram_cs_c   = 1'b1;
            ram_wr_c   = win_wr;
            ram_addr_c = win_addr;
            ram_din_c  = win_wdata;
          end
        end
        S_CLEAR: begin
          ram_cs_c   = 1'b1;
          ram_wr_c   = 1'b1;
          ram_addr_c = cnt_q;
          ram_din_c  = '0;
        end
        default: begin
          ram_cs_c = 1'b0;
        end
      endcase
    end
  end

  // FSM state, round-robin pointer and clear counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Requester-facing registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign bus.a_ack    = a_ack_q;
  assign bus.b_ack    = b_ack_q;
  assign bus.a_rdata  = a_rdata_q;
  assign bus.b_rdata  = b_rdata_q;
  assign bus.clr_busy = clr_busy_c;
  assign bus.ram_cs   = ram_cs_c;
  assign bus.ram_wr   = ram_wr_c;
  assign bus.ram_addr = ram_addr_c;
  assign bus.ram_din  = ram_din_c;

endmodule
